// File: rtl/mmcm_reset_sequencer.sv
// rtl/mmcm_reset_sequencer.sv - MMCM reset pulse / lock qualification sequencer, system reset release
// Optional build macro MMCM_RESET_SEQ_AUTO_RECOVER_EN: lock loss in RUN re-runs the MMCM reset instead of halting.
module mmcm_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int SYNC_STAGES         = 3
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       mmcm_locked,
    output logic       mmcm_reset,
    output logic       sys_reset,
    output logic [1:0] state,
    output logic [7:0] retry_count,
    output logic       timeout
);

    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // ST_HALT is the terminal lock-loss state; it reports the RESET_MMCM encoding on the state port.
    typedef enum logic [2:0] {
        ST_RESET_MMCM = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_HALT       = 3'd4
    } state_t;

    state_t                 cur_st;
    state_t                 nxt_st;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   retry_inc;
    logic                   timeout_nxt;

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign state    = cur_st[1:0];

    always_comb begin
        nxt_st      = cur_st;
        retry_inc   = 1'b0;
        timeout_nxt = 1'b0;
        case (cur_st)
            ST_RESET_MMCM: begin
                if (cnt == CNT_W'(RST_PULSE_CYCLES - 1))
                    nxt_st = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    nxt_st = ST_STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    nxt_st      = ST_RESET_MMCM;
                    timeout_nxt = 1'b1;
                    retry_inc   = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s)
                    nxt_st = ST_WAIT_LOCK;
                else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1))
                    nxt_st = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) begin
                    retry_inc = 1'b1;
`ifdef MMCM_RESET_SEQ_AUTO_RECOVER_EN
                    nxt_st = ST_RESET_MMCM;
`else
                    nxt_st = ST_HALT;
`endif
                end
            end
            default: nxt_st = cur_st;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            cur_st      <= ST_RESET_MMCM;
            cnt         <= '0;
            sync_q      <= '0;
            mmcm_reset  <= 1'b1;
            sys_reset   <= 1'b1;
            retry_count <= 8'd0;
            timeout     <= 1'b0;
        end else begin
            cur_st <= nxt_st;
            if (nxt_st != cur_st || cur_st == ST_RUN || cur_st == ST_HALT)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            // Flushing during the MMCM reset keeps a pre-reset lock from leaking into WAIT_LOCK.
            if (cur_st == ST_RESET_MMCM)
                sync_q <= '0;
            else
                sync_q <= {sync_q[SYNC_STAGES-2:0], mmcm_locked};
            mmcm_reset <= (nxt_st == ST_RESET_MMCM);
            sys_reset  <= (nxt_st != ST_RUN);
            timeout    <= timeout_nxt;
            if (retry_inc && retry_count != 8'hff)
                retry_count <= retry_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// tb/tb_mmcm_reset_sequencer.sv - self-checking bench for mmcm_reset_sequencer
module tb_mmcm_reset_sequencer;

    localparam int RST  = 4;
    localparam int TO   = 50;
    localparam int STB  = 8;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mmcm_locked = 1'b0;
    logic       mmcm_reset;
    logic       sys_reset;
    logic [1:0] state;
    logic [7:0] retry_count;
    logic       timeout;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int tpulses = 0;

    always #5 clk = ~clk;

    mmcm_reset_sequencer #(
        .RST_PULSE_CYCLES   (RST),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES (STB),
        .SYNC_STAGES        (SYNC)
    ) dut (
        .clk_100mhz (clk),
        .reset      (reset),
        .mmcm_locked(mmcm_locked),
        .mmcm_reset (mmcm_reset),
        .sys_reset  (sys_reset),
        .state      (state),
        .retry_count(retry_count),
        .timeout    (timeout)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (timeout === 1'b1) tpulses++;
    endtask

    task automatic tick_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mmcm_reset"}, mmcm_reset, 1);
        chk({tag, "_sys_reset"}, sys_reset, 1);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_retry"}, retry_count, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mmcm_locked = 1'b0;
        #1 chk_reset_vals("rst_async");
        tick();
        tick();
        chk_reset_vals("rst_held");
        reset = 1'b0;
        cyc = 0;
        tpulses = 0;
    endtask

    // Edge (after reset release) at which sys_reset falls when mmcm_locked is first sampled high
    // at edge e0 and held: each failed attempt costs TO+RST edges; lock samples before WAIT_LOCK are flushed.
    function automatic void predict(input int e0, output int fall, output int retries);
        int w;
        int e;
        w = RST;
        retries = 0;
        fall = -1;
        for (int a = 0; a < 20; a++) begin
            e = (e0 > w + 1) ? e0 : w + 1;
            if (e + SYNC <= w + TO) begin
                fall = e + SYNC + STB;
                return;
            end
            retries++;
            w += TO + RST;
        end
    endfunction

    initial begin
        int e0_list[8];
        int fall;
        int r;
        int d;
        int g;
        int e1;
        int p;

        // Pulse width and first lock timeout.
        do_reset();
        for (int k = 1; k < RST; k++) begin
            tick();
            chk("t1_pulse_hi", mmcm_reset, 1);
        end
        tick();
        chk("t1_pulse_lo", mmcm_reset, 0);
        chk("t1_wait_state", state, 1);
        tick_to(RST + TO - 1);
        chk("t1_no_timeout_yet", timeout, 0);
        chk("t1_still_wait", state, 1);
        tick();
        chk("t1_timeout", timeout, 1);
        chk("t1_retry", retry_count, 1);
        chk("t1_repulse", mmcm_reset, 1);
        chk("t1_state_rst", state, 0);
        tick_to(2 * RST + TO - 1);
        chk("t1_repulse_hi", mmcm_reset, 1);
        chk("t1_timeout_once", timeout, 0);
        tick();
        chk("t1_repulse_lo", mmcm_reset, 0);

        // Lock arrival at directed and random times against the arithmetic model.
        e0_list[0] = RST + 1 + 10;
        e0_list[1] = RST + TO - SYNC;
        e0_list[2] = RST + TO - SYNC + 1;
        e0_list[3] = 1;
        for (int i = 4; i < 8; i++) e0_list[i] = $urandom_range(70, 1);
        for (int i = 0; i < 8; i++) begin
            do_reset();
            predict(e0_list[i], fall, r);
            tick_to(e0_list[i] - 1);
            mmcm_locked = 1'b1;
            tick_to(fall - 1);
            chk("t2_sysrst_hi", sys_reset, 1);
            tick();
            chk("t2_sysrst_lo", sys_reset, 0);
            chk("t2_state_run", state, 3);
            chk("t2_retry", retry_count, r);
            chk("t2_timeouts", tpulses, r);
            chk("t2_mmcm_lo", mmcm_reset, 0);
        end

        // Lock glitch during STABLE restarts the stable count.
        do_reset();
        tick_to(RST + 10);
        mmcm_locked = 1'b1;
        p = $urandom_range(5, 0);
        g = $urandom_range(3, 1);
        d = RST + 11 + 1 + p;
        tick_to(d - 1);
        mmcm_locked = 1'b0;
        tick_to(d - 1 + g);
        mmcm_locked = 1'b1;
        e1 = d + g;
        tick_to(d + 2);
        chk("t3_back_to_wait", state, 1);
        chk("t3_sysrst_hi", sys_reset, 1);
        tick_to(e1 + 2);
        chk("t3_stable_again", state, 2);
        tick_to(e1 + SYNC + STB - 1);
        chk("t3_sysrst_hold", sys_reset, 1);
        tick();
        chk("t3_sysrst_lo", sys_reset, 0);
        chk("t3_state_run", state, 3);
        chk("t3_retry", retry_count, 0);

        // Lock loss in RUN.
        d = cyc + 2;
        tick();
        mmcm_locked = 1'b0;
        tick_to(d + 1);
        chk("t4_still_run", sys_reset, 0);
        tick();
        chk("t4_sysrst_hi", sys_reset, 1);
        chk("t4_retry", retry_count, 1);
        chk("t4_state", state, 0);
`ifdef MMCM_RESET_SEQ_AUTO_RECOVER_EN
        chk("t4_repulse", mmcm_reset, 1);
        tick_to(d + 1 + RST);
        chk("t4_repulse_hi", mmcm_reset, 1);
        tick();
        chk("t4_repulse_lo", mmcm_reset, 0);
        chk("t4_wait", state, 1);
`else
        chk("t4_no_pulse", mmcm_reset, 0);
        for (int k = 0; k < 100; k++) begin
            mmcm_locked = 1'($urandom_range(1, 0));
            tick();
            chk("t4_halt_state", state, 0);
            chk("t4_halt_mmcm", mmcm_reset, 0);
            chk("t4_halt_sysrst", sys_reset, 1);
        end
        chk("t4_halt_retry", retry_count, 1);
`endif

        // Back-to-back timeouts saturate retry_count.
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            tick_to(k * (TO + RST));
            chk("t5_timeout", timeout, 1);
            chk("t5_retry", retry_count, (k > 255) ? 255 : k);
        end
        chk("t5_pulses", tpulses, 300);

        // Asynchronous reset in WAIT_LOCK.
        tick_to(300 * (TO + RST) + RST + 20);
        chk("t6_wait", state, 1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("t6_async");
        tick();
        reset = 1'b0;
        cyc = 0;
        for (int k = 1; k < RST; k++) begin
            tick();
            chk("t6_pulse_hi", mmcm_reset, 1);
        end
        tick();
        chk("t6_pulse_lo", mmcm_reset, 0);
        chk("t6_state", state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
